// File: rtl/bnn_conv5x5_xnor.sv
// ---------------------------------------------------------------------------
// bnn_conv5x5_xnor
//
// Binary 5x5 convolution stage that sits behind a 5x5 column shift buffer.
// Each accepted column shift presents a 25-bit binary window. The window is
// XNORed with a loaded 25-bit kernel (1 = +1, 0 = -1) and the matches are
// popcounted. The popcount is then compared against a threshold to give one
// binarized activation bit per complete window. The block also tracks
// window fill per image row, tags every result with its column position and
// flags rows that receive more than IMG_W columns.
//
// Parameters
//   IMG_W     image width in columns (>= 5)
//   COL_W     width of out_col_o, 2**COL_W > IMG_W-5
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en_i         column shift strobe shared with the column buffer
//   row_start_i  one-cycle pulse marking the first column of a row
//   window_i     25-bit window {col4..col0}; bit i pairs with weight bit i
//   w_load_i     loads w_data_i and thresh_in_i
//   w_data_i     kernel weights
//   thresh_in_i  activation threshold (values above 25 never fire)
//   out_valid_o  one-cycle result strobe
//   out_bit_o    1 when popcount >= threshold
//   out_pop_o    popcount 0..25
//   out_col_o    window index within the row
//   out_last_o   last window of the row (qualified by out_valid_o)
//   ovf_o        sticky: more than IMG_W columns since row_start_i
//
// Pipeline: en sampled at edge N -> window read at N+1 (stage 1),
// popcount at N+2 (stage 2), outputs at N+3.
// ---------------------------------------------------------------------------
module bnn_conv5x5_xnor #(
  parameter int IMG_W = 28,
  parameter int COL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             row_start_i,
  input  logic [24:0]      window_i,
  input  logic             w_load_i,
  input  logic [24:0]      w_data_i,
  input  logic [4:0]       thresh_in_i,
  output logic             out_valid_o,
  output logic             out_bit_o,
  output logic [4:0]       out_pop_o,
  output logic [COL_W-1:0] out_col_o,
  output logic             out_last_o,
  output logic             ovf_o
);

  // Column counter must hold IMG_W+1 so the first excess column is visible.
  localparam int               CNT_W     = $clog2(IMG_W + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(IMG_W + 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 5);
  localparam logic [2:0]       FILL_FULL = 3'd5;

  // Number of set bits in a 25-bit vector (0..25 fits in 5 bits).
  function automatic logic [4:0] popcount25(input logic [24:0] vec);
    logic [4:0] acc;
    acc = 5'd0;
    for (int i = 0; i < 25; i++) begin
      acc = acc + {4'd0, vec[i]};
    end
    return acc;
  endfunction

  // Row bookkeeping
  logic [2:0]       fill_q,    fill_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic             ovf_q,     ovf_d;
  logic [COL_W-1:0] pos_q,     pos_d;
  logic             en_d_q;

  // Kernel configuration
  logic [24:0]      weights_q, weights_d;
  logic [4:0]       thr_q,     thr_d;

  // Stage 1
  logic             v1_q,      v1_d;
  logic [24:0]      xnor1_q,   xnor1_d;
  logic [4:0]       thr1_q,    thr1_d;
  logic [COL_W-1:0] col1_q,    col1_d;

  // Stage 2
  logic             v2_q,      v2_d;
  logic [4:0]       pop2_q,    pop2_d;
  logic [4:0]       thr2_q,    thr2_d;
  logic [COL_W-1:0] col2_q,    col2_d;

  // Output stage
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q,   out_bit_d;
  logic [4:0]       out_pop_q,   out_pop_d;
  logic [COL_W-1:0] out_col_q,   out_col_d;
  logic             out_last_q,  out_last_d;

  // Window fill: saturates at 5; a row_start with en counts that column as
  // the first of the new row.
  always_comb begin
    fill_d = fill_q;
    if (row_start_i) begin
      if (en_i) begin
        fill_d = 3'd1;
      end else begin
        fill_d = 3'd0;
      end
    end else if (en_i && (fill_q != FILL_FULL)) begin
      fill_d = fill_q + 3'd1;
    end else begin
      fill_d = fill_q;
    end
  end

  // Columns since row_start and the sticky overflow flag.
  always_comb begin
    col_cnt_d = col_cnt_q;
    ovf_d     = ovf_q;
    if (row_start_i) begin
      ovf_d = 1'b0;
      if (en_i) begin
        col_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        col_cnt_d = {CNT_W{1'b0}};
      end
    end else if (en_i) begin
      // Reaching IMG_W already means this pulse is column IMG_W+1.
      if (col_cnt_q == CNT_LIMIT) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (col_cnt_q != CNT_SAT) begin
        col_cnt_d = col_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        col_cnt_d = col_cnt_q;
      end
    end else begin
      col_cnt_d = col_cnt_q;
      ovf_d     = ovf_q;
    end
  end

  // Kernel and threshold registers; a capture on the load edge sees old values.
  always_comb begin
    weights_d = weights_q;
    thr_d     = thr_q;
    if (w_load_i) begin
      weights_d = w_data_i;
      thr_d     = thresh_in_i;
    end else begin
      weights_d = weights_q;
      thr_d     = thr_q;
    end
  end

  // Stage 1: the buffer has shifted on the en edge, so the window is read one
  // cycle later. fill/ovf here still reflect that en column, before any
  // row_start on this same edge takes effect.
  always_comb begin
    v1_d    = en_d_q & (fill_q == FILL_FULL) & ~ovf_q;
    xnor1_d = xnor1_q;
    thr1_d  = thr1_q;
    col1_d  = col1_q;
    if (en_d_q) begin
      xnor1_d = ~(window_i ^ weights_q);
      thr1_d  = thr_q;
      col1_d  = pos_q;
    end else begin
      xnor1_d = xnor1_q;
      thr1_d  = thr1_q;
      col1_d  = col1_q;
    end
  end

  // Window position: the window entering stage 1 on a row_start edge belongs
  // to the old row and keeps its tag; only later windows restart at 0.
  always_comb begin
    pos_d = pos_q;
    if (row_start_i) begin
      pos_d = {COL_W{1'b0}};
    end else if (v1_d) begin
      pos_d = pos_q + {{(COL_W-1){1'b0}}, 1'b1};
    end else begin
      pos_d = pos_q;
    end
  end

  // Stage 2: popcount of the match vector.
  always_comb begin
    v2_d   = v1_q;
    pop2_d = pop2_q;
    thr2_d = thr2_q;
    col2_d = col2_q;
    if (v1_q) begin
      pop2_d = popcount25(xnor1_q);
      thr2_d = thr1_q;
      col2_d = col1_q;
    end else begin
      pop2_d = pop2_q;
      thr2_d = thr2_q;
      col2_d = col2_q;
    end
  end

  // Output stage: data outputs hold between results; strobes are one cycle.
  always_comb begin
    out_valid_d = v2_q;
    out_bit_d   = out_bit_q;
    out_pop_d   = out_pop_q;
    out_col_d   = out_col_q;
    out_last_d  = 1'b0;
    if (v2_q) begin
      out_bit_d  = (pop2_q >= thr2_q);
      out_pop_d  = pop2_q;
      out_col_d  = col2_q;
      out_last_d = (col2_q == LAST_COL);
    end else begin
      out_bit_d  = out_bit_q;
      out_pop_d  = out_pop_q;
      out_col_d  = out_col_q;
      out_last_d = 1'b0;
    end
  end

  // State registers; reset drops all in-flight windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q      <= 3'd0;
      col_cnt_q   <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      pos_q       <= {COL_W{1'b0}};
      en_d_q      <= 1'b0;
      weights_q   <= 25'd0;
      thr_q       <= 5'd0;
      v1_q        <= 1'b0;
      xnor1_q     <= 25'd0;
      thr1_q      <= 5'd0;
      col1_q      <= {COL_W{1'b0}};
      v2_q        <= 1'b0;
      pop2_q      <= 5'd0;
      thr2_q      <= 5'd0;
      col2_q      <= {COL_W{1'b0}};
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_pop_q   <= 5'd0;
      out_col_q   <= {COL_W{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      col_cnt_q   <= col_cnt_d;
      ovf_q       <= ovf_d;
      pos_q       <= pos_d;
      en_d_q      <= en_i;
      weights_q   <= weights_d;
      thr_q       <= thr_d;
      v1_q        <= v1_d;
      xnor1_q     <= xnor1_d;
      thr1_q      <= thr1_d;
      col1_q      <= col1_d;
      v2_q        <= v2_d;
      pop2_q      <= pop2_d;
      thr2_q      <= thr2_d;
      col2_q      <= col2_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_pop_q   <= out_pop_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_bit_o   = out_bit_q;
  assign out_pop_o   = out_pop_q;
  assign out_col_o   = out_col_q;
  assign out_last_o  = out_last_q;
  assign ovf_o       = ovf_q;

endmodule
